// File: rtl/dnn_vec_register_file.sv
// dnn_vec_register_file: NREG x XLEN register file with two combinational
// scalar read ports, a core write port, a DNN writeback port, and a vector
// read sequencer that streams a contiguous register block, VLANES per beat,
// over valid/ready.
// Optional macro RF_BYPASS_EN: forward same-cycle writes to the scalar reads
// and to beat loads.
module dnn_vec_register_file #(
    parameter  int XLEN   = 32,
    parameter  int NREG   = 32,
    parameter  int VLANES = 2,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AW-1:0]            RR1,
    input  logic [AW-1:0]            RR2,
    output logic [XLEN-1:0]          RD1,
    output logic [XLEN-1:0]          RD2,
    input  logic                     RegWrite,
    input  logic [AW-1:0]            WR,
    input  logic [XLEN-1:0]          WD,
    input  logic                     DnnWrite,
    input  logic [AW-1:0]            WR2,
    input  logic [XLEN-1:0]          WDD,
    input  logic                     vec_start,
    input  logic [AW-1:0]            vec_base,
    input  logic [AW:0]              vec_len,
    output logic                     vec_busy,
    output logic                     vec_valid,
    input  logic                     vec_ready,
    output logic [VLANES*XLEN-1:0]   vec_data,
    output logic [VLANES-1:0]        vec_mask,
    output logic                     vec_last
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    logic [XLEN-1:0]        regs_q [NREG];
    logic [XLEN-1:0]        regs_d [NREG];

    state_t                 state_q, state_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic [AW:0]            rem_q, rem_d;
    logic [VLANES*XLEN-1:0] data_q, data_d;
    logic [VLANES-1:0]      mask_q, mask_d;
    logic                   last_q, last_d;

    logic [AW-1:0]          load_ptr;
    logic [AW:0]            load_rem;
    logic [VLANES*XLEN-1:0] beat_data;
    logic [VLANES-1:0]      beat_mask;
    logic                   beat_last;

    // Next register contents: DNN write first so a colliding core write wins;
    // register 0 is pinned to zero.
    always_comb begin
        regs_d = regs_q;
        if (DnnWrite) regs_d[WR2] = WDD;
        if (RegWrite) regs_d[WR]  = WD;
        regs_d[0] = '0;
    end

    // Scalar reads: regs_d already carries same-cycle writes with priority
    // and a zero register 0, so it doubles as the forwarding path.
    always_comb begin
`ifdef RF_BYPASS_EN
        RD1 = regs_d[RR1];
        RD2 = regs_d[RR2];
`else
        RD1 = regs_q[RR1];
        RD2 = regs_q[RR2];
`endif
    end

    // Candidate beat: the first beat of a new block in IDLE, or the beat
    // following the presented one in STREAM.
    always_comb begin
        logic [AW-1:0] lane_addr;
        lane_addr = '0;
        load_ptr  = (state_q == IDLE) ? vec_base : ptr_q + AW'(VLANES);
        load_rem  = (state_q == IDLE) ? vec_len  : rem_q - (AW+1)'(VLANES);
        beat_data = '0;
        beat_mask = '0;
        for (int unsigned i = 0; i < VLANES; i++) begin
            lane_addr = load_ptr + AW'(i);
            if ((AW+1)'(i) < load_rem) begin
                beat_mask[i] = 1'b1;
`ifdef RF_BYPASS_EN
                beat_data[i*XLEN +: XLEN] = regs_d[lane_addr];
`else
                beat_data[i*XLEN +: XLEN] = regs_q[lane_addr];
`endif
            end
        end
        beat_last = (load_rem <= (AW+1)'(VLANES));
    end

    // Sequencer next state: load a beat on start or on a non-last handshake,
    // clear the snapshot when the last beat is taken.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        mask_d  = mask_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (vec_start && (vec_len != '0)) begin
                    state_d = STREAM;
                    ptr_d   = load_ptr;
                    rem_d   = load_rem;
                    data_d  = beat_data;
                    mask_d  = beat_mask;
                    last_d  = beat_last;
                end
            end
            STREAM: begin
                if (vec_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        data_d  = '0;
                        mask_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        ptr_d  = load_ptr;
                        rem_d  = load_rem;
                        data_d = beat_data;
                        mask_d = beat_mask;
                        last_d = beat_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NREG; k++) regs_q[k] <= '0;
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
        end
    end

    assign vec_valid = (state_q == STREAM);
    assign vec_busy  = (state_q == STREAM);
    assign vec_data  = data_q;
    assign vec_mask  = mask_q;
    assign vec_last  = last_q;

endmodule

// File: doc/dnn_vec_register_file.md
Name: dnn_vec_register_file

Overview:
- Parametrised successor to the core register file.
- Keeps two combinational scalar read ports and two write ports: the core write port and the DNN-writeback port.
- Replaces the ad-hoc DnnSel read mode with a vector read sequencer. The sequencer streams a contiguous block of registers to the DNN engine over a valid/ready interface, VLANES registers per beat.
- Sits between the CPU datapath/writeback and the DNN accelerator.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers; power of two, at least 4.
- VLANES, 2, registers delivered per stream beat; 1 to NREG.
- AW, $clog2(NREG), register address width (derived, not overridden).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- RR1, RR2  in  AW  scalar read addresses
- RD1, RD2  out  XLEN  scalar read data, combinational
- RegWrite  in  1  core write enable
- WR  in  AW  core write address
- WD  in  XLEN  core write data
- DnnWrite  in  1  DNN writeback enable
- WR2  in  AW  DNN write address
- WDD  in  XLEN  DNN write data
- vec_start  in  1  start-stream request, one-cycle pulse
- vec_base  in  AW  first register of the block
- vec_len  in  AW+1  number of registers, 0..NREG
- vec_busy  out  1  sequencer not idle
- vec_valid  out  1  beat available
- vec_ready  in  1  consumer accepts beat
- vec_data  out  VLANES*XLEN  lane i in bits [i*XLEN +: XLEN]
- vec_mask  out  VLANES  lane-valid bits
- vec_last  out  1  current beat is the final one

Behaviour:
- Reset:
  - All registers are set to 0 and the FSM goes to IDLE.
  - vec_valid, vec_busy, vec_last, vec_mask and vec_data are 0.
  - Reset asserted mid-stream aborts the stream; no further beats are produced.
- Register 0:
  - Always reads 0.
  - Writes to address 0 from either port are dropped.
- Writes:
  - Both ports may write in the same cycle.
  - If WR==WR2 and both are enabled, the RegWrite value wins.
  - Writes are visible on RD1/RD2 from the next cycle. Same-cycle reads return the old value unless BYPASS_EN is defined.
- Sequencer FSM, states IDLE and STREAM:
  - IDLE: vec_start with vec_len!=0 latches ptr=vec_base and rem=vec_len, loads beat 0, and moves to STREAM. vec_valid rises the next cycle, giving a start-to-valid latency of 1.
  - IDLE: vec_start with vec_len==0 is ignored and the FSM stays in IDLE.
  - STREAM: vec_busy=1 and vec_valid=1.
  - Beat contents: lane i = reg[(ptr+i) mod NREG], so addressing wraps at NREG. vec_mask[i] = (i < rem). Masked-off lanes carry 0. vec_last = (rem <= VLANES).
  - Handshake (vec_valid && vec_ready) on a non-last beat: ptr += VLANES mod NREG, rem -= VLANES, and the next beat loads, so a new beat can be presented every cycle.
  - Handshake on the last beat: return to IDLE, and vec_valid, vec_busy, vec_mask and vec_last go to 0 next cycle.
  - vec_start during STREAM, including in the last-handshake cycle, is ignored.
- Beat snapshot:
  - vec_data/vec_mask/vec_last are registered at beat load and held stable while vec_valid && !vec_ready.
  - Register writes after load do not alter the presented beat.
  - A write in the same cycle as a beat load is not captured; the beat holds the pre-write value.
- Counter width: rem is AW+1 bits, so vec_len==NREG streams the whole file once, wrapping from vec_base.

Optional Feature:
- Macro: RF_BYPASS_EN.
- When defined: RD1/RD2 forward same-cycle write data when the read address matches an enabled write. The RegWrite value has priority over DnnWrite. Address 0 is never forwarded.
- Beat loads also forward same-cycle writes, so the snapshot includes the write.
- When undefined: no forwarding; reads and beat loads see pre-write contents as described above.

Test Plan:
- Reset, then write reg5=0xA5A5_0001 via RegWrite and reg5=0x1234 via DnnWrite in the same cycle; read RR1=5 next cycle -> RD1=0xA5A5_0001. Write reg0=0xFFFF_FFFF -> RD1 for RR1=0 is 0.
- VLANES=2: load reg k=k*16 for k=1..31. Pulse vec_start, base=3, len=5, ready held 1 -> 3 beats on consecutive cycles: (0x30,0x40) mask 11; (0x50,0x60) mask 11; (0x70,0) mask 01 with vec_last=1. vec_busy drops the cycle after.
- Wrap: base=30, len=4 -> beats (reg30,reg31) then (0x0,reg1), last=1.
- Backpressure: hold ready 0 for 4 cycles on beat 0 while writing reg3=0xDEAD -> vec_data unchanged (0x30) throughout. vec_start pulsed mid-stream is ignored.
- vec_len=0 start -> vec_busy stays 0. vec_len=32 -> 16 beats covering all registers. rst asserted during beat 2 -> vec_valid=0 next cycle and all registers 0.
- With RF_BYPASS_EN: write reg7=0x77 while RR2=7 -> RD2=0x77 in the same cycle. Without it -> RD2 shows the old value.
